// File: rtl/video_timing_pkg.sv
// Video mode constants shared by the capture block and the framebuffer timing generator.
package video_timing_pkg;

  localparam int unsigned CNT_W   = 13;
  localparam int unsigned CNT_MAX = 8191;

  typedef struct packed {
    logic [7:0] fp;
    logic [7:0] sync;
    logic [7:0] bp;
  } porch_t;

  // Active width for a mode; mode 4 is a compact 8x4 bring-up mode
  function automatic int unsigned frame_h(input int unsigned mode);
    case (mode)
      4:       return 8;
      600:     return 800;
      720:     return 1280;
      1080:    return 1920;
      default: return 640;
    endcase
  endfunction

  // Active line count for a mode
  function automatic int unsigned frame_v(input int unsigned mode);
    case (mode)
      4:       return 4;
      600:     return 600;
      720:     return 720;
      1080:    return 1080;
      default: return 480;
    endcase
  endfunction

  // Horizontal front porch / sync / back porch in pixels
  function automatic porch_t h_porch(input int unsigned mode);
    case (mode)
      4:       return '{fp: 8'd2,   sync: 8'd2,   bp: 8'd2};
      600:     return '{fp: 8'd40,  sync: 8'd128, bp: 8'd88};
      720:     return '{fp: 8'd110, sync: 8'd40,  bp: 8'd220};
      1080:    return '{fp: 8'd88,  sync: 8'd44,  bp: 8'd148};
      default: return '{fp: 8'd16,  sync: 8'd96,  bp: 8'd48};
    endcase
  endfunction

  // Vertical front porch / sync / back porch in lines
  function automatic porch_t v_porch(input int unsigned mode);
    case (mode)
      4:       return '{fp: 8'd1,  sync: 8'd1, bp: 8'd1};
      600:     return '{fp: 8'd1,  sync: 8'd4, bp: 8'd23};
      720:     return '{fp: 8'd5,  sync: 8'd5, bp: 8'd20};
      1080:    return '{fp: 8'd4,  sync: 8'd5, bp: 8'd36};
      default: return '{fp: 8'd10, sync: 8'd2, bp: 8'd33};
    endcase
  endfunction

endpackage

// File: rtl/video_geom_meter.sv
// Input registering, sync edge detection, x/y counting and frame geometry verdict.
module video_geom_meter
  import video_timing_pkg::*;
#(
  parameter int unsigned FRAME_W          = 640,
  parameter int unsigned FRAME_V          = 480,
  parameter int unsigned VSYNC_ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vde_i,
  input  logic             vsync_i,
  output logic             vs_rise_c_o,
  output logic             line_end_c_o,
  output logic             active_c_o,
  output logic             frame_good_c_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic [CNT_W-1:0] meas_width_o,
  output logic [CNT_W-1:0] meas_height_o
);

  localparam logic VS_INV = (VSYNC_ACTIVE_LOW != 0);

  logic             vde_q, vde_p_q, vs_q, vs_p_q;
  logic             void_q, void_d, bad_q, bad_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d, mw_q, mw_d, mh_q, mh_d;
  logic             vs_rise, vde_fall;

  // A line cut by vsync is void: it is neither measured nor written
  assign vs_rise        = vs_q & ~vs_p_q;
  assign vde_fall       = vde_p_q & ~vde_q;
  assign line_end_c_o   = vde_fall & ~void_q & ~vs_rise;
  assign active_c_o     = vde_q & ~void_q & ~vs_rise;
  assign vs_rise_c_o    = vs_rise;
  assign frame_good_c_o = (y_q == CNT_W'(FRAME_V)) & ~bad_q;
  assign x_o            = x_q;
  assign y_o            = y_q;
  assign meas_width_o   = mw_q;
  assign meas_height_o  = mh_q;

  // Stage-0 input registers plus one cycle of history for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vde_q   <= 1'b0;
      vde_p_q <= 1'b0;
      vs_q    <= 1'b0;
      vs_p_q  <= 1'b0;
    end else begin
      vde_q   <= vde_i;
      vde_p_q <= vde_q;
      vs_q    <= vsync_i ^ VS_INV;
      vs_p_q  <= vs_q;
    end
  end

  // Counter, measurement and verdict next-state
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    mw_d   = mw_q;
    mh_d   = mh_q;
    bad_d  = bad_q;
    void_d = void_q;
    if (vs_rise) begin
      x_d    = '0;
      y_d    = '0;
      mh_d   = y_q;
      bad_d  = 1'b0;
      void_d = vde_q;
    end else begin
      if (vde_fall) begin
        x_d    = '0;
        void_d = 1'b0;
      end else if (active_c_o && x_q != CNT_W'(CNT_MAX)) begin
        x_d = x_q + CNT_W'(1);
      end
      if (line_end_c_o) begin
        mw_d = x_q;
        if (x_q != CNT_W'(FRAME_W)) bad_d = 1'b1;
        if (y_q != CNT_W'(CNT_MAX)) y_d = y_q + CNT_W'(1);
      end
    end
  end

  // Counter and measurement registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      mw_q   <= '0;
      mh_q   <= '0;
      bad_q  <= 1'b0;
      void_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      mw_q   <= mw_d;
      mh_q   <= mh_d;
      bad_q  <= bad_d;
      void_q <= void_d;
    end
  end

endmodule

// File: rtl/rgb2fbuf_capture.sv
// Captures a decimated pixel stream into a linear framebuffer once geometry is locked.
module rgb2fbuf_capture
  import video_timing_pkg::*;
#(
  parameter int unsigned FRAME_HEIGHT     = 480,
  parameter int unsigned SCALING_FACTOR   = 1,
  parameter int unsigned FBUF_ADDR_WIDTH  = 19,
  parameter int unsigned PIXEL_WIDTH      = 24,
  parameter int unsigned VSYNC_ACTIVE_LOW = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       vid_vde,
  input  logic                       vid_vsync,
  input  logic [PIXEL_WIDTH-1:0]     vid_pdata,
  output logic                       fbuf_we,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  output logic [PIXEL_WIDTH-1:0]     fbuf_wdata,
  output logic                       locked,
  output logic                       sof,
  output logic                       geom_err,
  output logic [12:0]                meas_width,
  output logic [12:0]                meas_height
);

  localparam int unsigned FRAME_W  = frame_h(FRAME_HEIGHT);
  localparam int unsigned FRAME_V  = frame_v(FRAME_HEIGHT);
  localparam int unsigned COLS     = FRAME_W / SCALING_FACTOR;
  localparam int unsigned ROWS     = FRAME_V / SCALING_FACTOR;
  localparam int unsigned SUB_W    = 2;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALING_FACTOR - 1);

  typedef enum logic [1:0] {
    WAIT_VSYNC = 2'd0,
    MEASURE    = 2'd1,
    LOCKED     = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic                       locked_q, geom_err_q, geom_err_d;
  logic [PIXEL_WIDTH-1:0]     pdata_q, wdata_q;
  logic [SUB_W-1:0]           xs_q, xs_d, ys_q, ys_d;
  logic [CNT_W-1:0]           col_q, col_d, row_q, row_d;
  logic [FBUF_ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_c;
  logic                       we_q, sof_q, keep_c;
  logic                       vs_rise, line_end, active, frame_good;
  logic [CNT_W-1:0]           x, y;

  video_geom_meter #(
    .FRAME_W          (FRAME_W),
    .FRAME_V          (FRAME_V),
    .VSYNC_ACTIVE_LOW (VSYNC_ACTIVE_LOW)
  ) u_meter (
    .clk            (clk),
    .rst_n          (rst_n),
    .vde_i          (vid_vde),
    .vsync_i        (vid_vsync),
    .vs_rise_c_o    (vs_rise),
    .line_end_c_o   (line_end),
    .active_c_o     (active),
    .frame_good_c_o (frame_good),
    .x_o            (x),
    .y_o            (y),
    .meas_width_o   (meas_width),
    .meas_height_o  (meas_height)
  );

  // Lock FSM next-state; every decision is taken at a vsync edge
  always_comb begin
    state_d    = state_q;
    geom_err_d = 1'b0;
    case (state_q)
      WAIT_VSYNC: if (vs_rise) state_d = MEASURE;
      MEASURE:    if (vs_rise && frame_good) state_d = LOCKED;
      LOCKED: begin
        if (vs_rise && !frame_good) begin
          state_d    = MEASURE;
          geom_err_d = 1'b1;
        end
      end
      default:    state_d = WAIT_VSYNC;
    endcase
  end

  // Decimation sub-counters and incremental address base
  always_comb begin
    xs_d   = xs_q;
    ys_d   = ys_q;
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    if (vs_rise) begin
      xs_d   = '0;
      ys_d   = '0;
      col_d  = '0;
      row_d  = '0;
      base_d = '0;
    end else if (line_end) begin
      xs_d  = '0;
      col_d = '0;
      ys_d  = (ys_q == SUB_LAST) ? '0 : ys_q + SUB_W'(1);
      if (ys_q == '0 && row_q < CNT_W'(ROWS)) begin
        row_d  = row_q + CNT_W'(1);
        base_d = base_q + FBUF_ADDR_WIDTH'(COLS);
      end
    end else if (active) begin
      xs_d = (xs_q == SUB_LAST) ? '0 : xs_q + SUB_W'(1);
      if (xs_q == '0 && col_q < CNT_W'(COLS)) col_d = col_q + CNT_W'(1);
    end
  end

  // Pixels outside the decimated frame are dropped rather than wrapped
  assign keep_c = locked_q && active && xs_q == '0 && ys_q == '0 &&
                  x < CNT_W'(FRAME_W) && y < CNT_W'(FRAME_V) &&
                  col_q < CNT_W'(COLS) && row_q < CNT_W'(ROWS);
  assign addr_c = base_q + FBUF_ADDR_WIDTH'(col_q);

  // State, pipeline and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_VSYNC;
      locked_q   <= 1'b0;
      geom_err_q <= 1'b0;
      pdata_q    <= '0;
      xs_q       <= '0;
      ys_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      base_q     <= '0;
      we_q       <= 1'b0;
      sof_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      locked_q   <= (state_d == LOCKED);
      geom_err_q <= geom_err_d;
      pdata_q    <= vid_pdata;
      xs_q       <= xs_d;
      ys_q       <= ys_d;
      col_q      <= col_d;
      row_q      <= row_d;
      base_q     <= base_d;
      we_q       <= keep_c;
      sof_q      <= keep_c && (addr_c == '0);
      if (keep_c) begin
        addr_q  <= addr_c;
        wdata_q <= pdata_q;
      end
    end
  end

  assign fbuf_we    = we_q;
  assign fbuf_addr  = addr_q;
  assign fbuf_wdata = wdata_q;
  assign locked     = locked_q;
  assign sof        = sof_q;
  assign geom_err   = geom_err_q;

endmodule

// File: tb/tb_rgb2fbuf_capture.sv
// Directed bench: 8x4 mode, one S=1 active-high instance and one S=2 active-low instance.
module tb_rgb2fbuf_capture;

  logic        clk, rst_n, vde, vs, vs_n;
  logic [23:0] pdata;

  logic        we1, lk1, sof1, ge1, we2, lk2, sof2, ge2;
  logic [18:0] addr1, addr2;
  logic [23:0] wd1, wd2;
  logic [12:0] mw1, mh1, mw2, mh2;

  assign vs_n = ~vs;

  rgb2fbuf_capture #(.FRAME_HEIGHT(4), .SCALING_FACTOR(1), .FBUF_ADDR_WIDTH(19),
                     .PIXEL_WIDTH(24), .VSYNC_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .vid_vde(vde), .vid_vsync(vs), .vid_pdata(pdata),
    .fbuf_we(we1), .fbuf_addr(addr1), .fbuf_wdata(wd1), .locked(lk1), .sof(sof1),
    .geom_err(ge1), .meas_width(mw1), .meas_height(mh1));

  rgb2fbuf_capture #(.FRAME_HEIGHT(4), .SCALING_FACTOR(2), .FBUF_ADDR_WIDTH(19),
                     .PIXEL_WIDTH(24), .VSYNC_ACTIVE_LOW(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .vid_vde(vde), .vid_vsync(vs_n), .vid_pdata(pdata),
    .fbuf_we(we2), .fbuf_addr(addr2), .fbuf_wdata(wd2), .locked(lk2), .sof(sof2),
    .geom_err(ge2), .meas_width(mw2), .meas_height(mh2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int nl; int bad_line; int bad_w; int rst_line;
    int wr1; int wr2; int lock; int gerr; int mw; int mh;
  } row_t;

  row_t        rows[13];
  int          n_cmp, n_bad;
  int          idx1, idx2, wr1, wr2, cur_fid, lock_prev;
  logic [23:0] h1, h2, e1, e2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero();
    chk("rst_we1", we1, 0);     chk("rst_addr1", addr1, 0); chk("rst_wdata1", wd1, 0);
    chk("rst_lock1", lk1, 0);   chk("rst_sof1", sof1, 0);   chk("rst_gerr1", ge1, 0);
    chk("rst_mw1", mw1, 0);     chk("rst_mh1", mh1, 0);
    chk("rst_we2", we2, 0);     chk("rst_addr2", addr2, 0); chk("rst_lock2", lk2, 0);
    chk("rst_mw2", mw2, 0);
  endtask

  // Input history: h2 is the pixel that must be on fbuf_wdata this cycle
  always @(posedge clk) begin
    h2 = h1;
    h1 = pdata;
  end

  // Write monitor: in-order addresses, pixel identity from address, latency and sof
  always @(negedge clk) begin
    if (rst_n) begin
      if (we1) begin
        e1 = {8'(cur_fid), 8'(idx1 / 8), 8'(idx1 % 8)};
        chk("addr1", addr1, idx1);
        chk("data1", wd1, e1);
        chk("lat1", wd1, h2);
        chk("sof1", sof1, idx1 == 0);
        idx1++;
        wr1++;
      end else begin
        chk("sof1_idle", sof1, 0);
      end
      if (we2) begin
        e2 = {8'(cur_fid), 8'(2 * (idx2 / 4)), 8'(2 * (idx2 % 4))};
        chk("addr2", addr2, idx2);
        chk("data2", wd2, e2);
        chk("lat2", wd2, h2);
        chk("sof2", sof2, idx2 == 0);
        idx2++;
        wr2++;
      end else begin
        chk("sof2_idle", sof2, 0);
      end
    end
  end

  task automatic send_body(input int fid, input row_t rw);
    int w;
    cur_fid = fid;
    idx1 = 0; idx2 = 0; wr1 = 0; wr2 = 0;
    for (int l = 0; l < rw.nl; l++) begin
      w = (l == rw.bad_line) ? rw.bad_w : 8;
      for (int x = 0; x < w; x++) begin
        vde   = 1'b1;
        pdata = {8'(fid), 8'(l), 8'(x)};
        if (l == rw.rst_line && x == 3) begin
          rst_n = 1'b0;
          #1;
          chk_zero();
        end
        if (l == rw.rst_line && x == 5) rst_n = 1'b1;
        tick();
      end
      vde   = 1'b0;
      pdata = '0;
      repeat (3) tick();
    end
    repeat (2) tick();
  endtask

  task automatic send_vsync(input row_t rw);
    vs = 1'b1;
    tick();
    chk("lock_hold1", lk1, lock_prev);
    chk("lock_hold2", lk2, lock_prev);
    tick();
    chk("lock1", lk1, rw.lock);  chk("lock2", lk2, rw.lock);
    chk("gerr1", ge1, rw.gerr);  chk("gerr2", ge2, rw.gerr);
    chk("mw1", mw1, rw.mw);      chk("mh1", mh1, rw.mh);
    chk("mw2", mw2, rw.mw);      chk("mh2", mh2, rw.mh);
    vs = 1'b0;
    tick();
    chk("gerr_pulse1", ge1, 0);
    chk("gerr_pulse2", ge2, 0);
    repeat (3) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // nl, bad_line, bad_w, rst_line, wr1, wr2, lock, gerr, mw, mh
    rows[0]  = '{4, -1, 0, -1,  0, 0, 0, 0, 8, 4};  // active video before first vsync
    rows[1]  = '{4, -1, 0, -1,  0, 0, 1, 0, 8, 4};  // measured frame, lock at its end
    rows[2]  = '{4, -1, 0, -1, 32, 8, 1, 0, 8, 4};  // locked clean frame
    rows[3]  = '{4,  3, 7, -1, 31, 8, 0, 1, 7, 4};  // short last line
    rows[4]  = '{4, -1, 0, -1,  0, 0, 1, 0, 8, 4};  // relock
    rows[5]  = '{5, -1, 0, -1, 32, 8, 0, 1, 8, 5};  // one extra line
    rows[6]  = '{4, -1, 0, -1,  0, 0, 1, 0, 8, 4};
    rows[7]  = '{4,  1, 10, -1, 32, 8, 0, 1, 8, 4}; // long line, extra pixels dropped
    rows[8]  = '{4, -1, 0, -1,  0, 0, 1, 0, 8, 4};
    rows[9]  = '{4, -1, 0, -1, 32, 8, 1, 0, 8, 4};
    rows[10] = '{4, -1, 0,  2, -1, -1, 0, 0, 8, 2}; // reset at pixel (3,2)
    rows[11] = '{4, -1, 0, -1,  0, 0, 1, 0, 8, 4};
    rows[12] = '{4, -1, 0, -1, 32, 8, 1, 0, 8, 4};

    n_cmp = 0; n_bad = 0;
    idx1 = 0; idx2 = 0; wr1 = 0; wr2 = 0; cur_fid = 0; lock_prev = 0;
    rst_n = 1'b0; vde = 1'b0; vs = 1'b0; pdata = '0;
    repeat (3) tick();
    chk_zero();
    rst_n = 1'b1;
    repeat (2) tick();

    for (int r = 0; r < 13; r++) begin
      send_body(r, rows[r]);
      if (rows[r].wr1 >= 0) begin
        chk("wcount1", wr1, rows[r].wr1);
        chk("wcount2", wr2, rows[r].wr2);
      end
      if (rows[r].rst_line >= 0) lock_prev = 0;
      send_vsync(rows[r]);
      lock_prev = rows[r].lock;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
